// File: rtl/add_seq_if.sv
// add_seq_if: start/operand/result bundle for the nibble-serial adder
interface add_seq_if #(parameter int NIBBLES = 4);
    logic                   start;
    logic [4*NIBBLES-1:0]   a;
    logic [4*NIBBLES-1:0]   b;
    logic                   ci;
    logic                   busy;
    logic                   done;
    logic [4*NIBBLES-1:0]   s;
    logic                   co;
    modport master (output start, a, b, ci, input busy, done, s, co);
    modport slave  (input start, a, b, ci, output busy, done, s, co);
endinterface

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: W-bit add computed one nibble per cycle through a shared 4-bit adder
module add_seq_ctrl #(parameter int NIBBLES = 4) (
    input logic    clk,
    input logic    rst,
    add_seq_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t         state;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [W-1:0]   s_r;
    logic [IW-1:0]  idx;
    logic           carry;
    logic           co_r;
    logic           busy_r;
    logic           done_r;
    logic [4:0]     nib;
    assign nib      = {1'b0, a_r[4*idx +: 4]} + {1'b0, b_r[4*idx +: 4]} + {4'b0, carry};
    assign bus.s    = s_r;
    assign bus.co   = co_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    // sequencer: capture on start, one nibble per RUN cycle, single DONE pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            s_r    <= '0;
            co_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_r    <= bus.a;
                    b_r    <= bus.b;
                    carry  <= bus.ci;
                    idx    <= '0;
                    s_r    <= '0;
                    co_r   <= 1'b0;
                    busy_r <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    s_r[4*idx +: 4] <= nib[3:0];
                    carry           <= nib[4];
                    if (idx == IW'(NIBBLES - 1)) begin
                        co_r   <= nib[4];
                        idx    <= '0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: scoreboard bench with a cycle-level arithmetic reference model
module tb_add_seq_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;
    typedef struct {
        logic [W:0] v;
        int         k;
    } exp_t;
    logic   clk = 1'b0;
    logic   rst = 1'b1;
    exp_t   q[$];
    int     cyc = 0;
    int     free = 0;
    logic [W:0] last = '0;
    int     n_chk = 0;
    int     n_fail = 0;
    add_seq_if #(.NIBBLES(N)) bus ();
    add_seq_ctrl #(.NIBBLES(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask
    // reference model: an add is accepted when idle, result due NIBBLES+1 cycles later
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            free = cyc + 1;
            last = '0;
        end else if (bus.start === 1'b1 && cyc >= free) begin
            q.push_back('{{1'b0, bus.a} + {1'b0, bus.b} + (W+1)'(bus.ci), cyc});
            free = cyc + N + 2;
        end
        cyc++;
    end
    // monitor: compare handshake outputs and result against the scoreboard head
    always @(negedge clk) begin
        logic exp_done;
        logic exp_busy;
        exp_done = q.size() > 0 && cyc == q[0].k + N + 1;
        exp_busy = q.size() > 0 && cyc > q[0].k;
        check("done", 32'(bus.done), 32'(exp_done));
        check("busy", 32'(bus.busy), 32'(exp_busy));
        if (exp_done) begin
            check("result", 32'({bus.co, bus.s}), 32'(q[0].v));
            last = q[0].v;
            void'(q.pop_front());
        end else if (q.size() == 0) begin
            check("hold", 32'({bus.co, bus.s}), 32'(last));
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic scramble();
        bus.a  = W'($urandom);
        bus.b  = W'($urandom);
        bus.ci = 1'($urandom);
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            tick();
            scramble();
        end
    endtask
    task automatic go(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        bus.ci    = c;
        tick();
        bus.start = 1'b0;
        scramble();
    endtask
    initial begin
        bus.start = 1'b0;
        scramble();
        repeat (3) tick();
        rst = 1'b0;
        idle(2);
        go(16'h1234, 16'h4321, 1'b0);
        idle(N + 1);
        go(16'hFFFF, 16'h0001, 1'b0);
        idle(N + 1);
        go(16'hFFFF, 16'hFFFF, 1'b1);
        idle(N + 1);
        go(16'h0000, 16'h0000, 1'b0);
        idle(N + 1);
        go(16'h0F0F, 16'h0101, 1'b0);
        tick();
        bus.start = 1'b1;
        bus.a     = 16'hAAAA;
        tick();
        bus.start = 1'b0;
        idle(3);
        go(16'h1111, 16'h2222, 1'b1);
        idle(N + 1);
        go(16'h8888, 16'h8888, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(2);
        go(16'hBEEF, 16'h4111, 1'b1);
        idle(N + 1);
        bus.start = 1'b1;
        repeat (10 * (N + 2)) begin
            scramble();
            tick();
        end
        bus.start = 1'b0;
        idle(N + 3);
        check("drain", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
